wdog_win_timer: RTL and testbench
=================================

# wdog_win_timer

Parametrised second-generation watchdog counter for the `d_ip_wdog` IP, the successor to the single-stage reload timer. The counter width and tick prescaler are configurable. The down-count is loaded from a run-time value. Expiry has two stages: the first timeout raises an interrupt, and a second timeout requests a system reset. An optional window mode flags a feed that arrives too early as a violation. The block sits between the watchdog register interface (which drives enable, feed, load and window values) and the SoC reset/interrupt controllers.

## Interface
- `WDOG_CNT`, default 16: counter, load value and window value width in bits (≥ 2).
- `PRE_DIV`, default 1: `fclk` cycles per count tick (≥ 1). 1 means tick every cycle.
- `fclk` in 1: single clock; all logic is on its rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `wdog_act` in 1: watchdog enable (level).
- `wdog_reload` in 1: feed request, one-cycle pulse, sampled each cycle.
- `wdog_load_val` in `WDOG_CNT`: reload value, sampled on every load event.
- `wdog_win_en` in 1: window mode enable (level).
- `wdog_win_val` in `WDOG_CNT`: window open threshold; a feed is legal only when count ≤ this value.
- `wdog_timer_cnt` out `WDOG_CNT`: current down-count.
- `wdog_state` out 2: IDLE=0, RUN=1, IRQ=2, EXPIRED=3.
- `wdog_irq` out 1: first-stage timeout interrupt (level); high only in IRQ.
- `wdog_rst_req` out 1: sticky reset request; high only in EXPIRED.
- `wdog_win_err` out 1: one-cycle pulse on a window violation.

## Operation
- **Prescaler.**
  - Internal counter `pre` runs 0..`PRE_DIV`-1 in RUN and IRQ.
  - `tick` is asserted when `pre` = `PRE_DIV`-1; `pre` then wraps to 0.
  - `pre` clears on every load event and in IDLE and EXPIRED.
- **A load event** sets cnt ← `wdog_load_val` and `pre` ← 0.
- **Event priority**, evaluated each cycle in RUN and IRQ, highest first: `wdog_act`=0, then `wdog_reload`, then `tick`.
- **IDLE**
  - cnt = 0.
  - `wdog_act`=1 → load event, go to RUN.
- **RUN**
  - `wdog_act`=0 → IDLE, cnt ← 0.
  - Legal reload → load event, stay in RUN.
  - `tick` with cnt ≠ 0 → cnt ← cnt−1.
  - `tick` with cnt = 0 → load event, go to IRQ.
- **IRQ**
  - `wdog_act`=0 → IDLE, cnt ← 0.
  - Legal reload → load event, go to RUN (clears `wdog_irq`).
  - `tick` with cnt ≠ 0 → decrement.
  - `tick` with cnt = 0 → EXPIRED.
- **Window violation**
  - Condition: `wdog_reload`=1 and `wdog_win_en`=1 and cnt > `wdog_win_val`, in RUN or IRQ.
  - Response: `wdog_win_err` pulses for one cycle, state goes to EXPIRED, cnt ← 0.
  - With `wdog_win_en`=0, every reload is legal.
- **EXPIRED**
  - Terminal state: cnt holds 0 and `wdog_rst_req`=1.
  - `wdog_act` and `wdog_reload` are ignored.
  - Only `sys_rst` exits this state.
- **Ignored inputs.** `wdog_reload` in IDLE is ignored, with no error.
- **Arithmetic.** Unsigned, `WDOG_CNT` bits. Cnt never wraps below 0 and never exceeds its last load value.
- **Live sampling.** `wdog_load_val` and `wdog_win_val` are sampled live. Changing them mid-count affects only the next load or reload comparison.
- **Zero load value.** `wdog_load_val`=0 is legal: every tick is a timeout.
- **Window threshold at or above load value.** When `wdog_win_val` ≥ the load value, the window is always open.

## Timing
- **Reset values** (asynchronous, on `sys_rst`=1): state IDLE, cnt 0, `pre` 0, `wdog_irq` 0, `wdog_rst_req` 0, `wdog_win_err` 0.
- **Registered outputs.** All outputs are registered. Every input-to-output response has 1-cycle latency.
- **Activation.** `wdog_act` rising in cycle N gives cnt = load and state = RUN in N+1.
- **Stage-1 timeout.** Entering RUN with load value L, IRQ is entered (L+1)·`PRE_DIV` cycles later, with cnt reloaded to L.
- **Stage-2 timeout.** Entering IRQ, EXPIRED is entered (L+1)·`PRE_DIV` cycles later.
- **Feed on a tick cycle.** Reload and `tick` in the same cycle: reload wins and no decrement occurs.
- **Disable versus feed.** `wdog_act`=0 and `wdog_reload`=1 in the same cycle: the block goes to IDLE, with no window check.
- **Disable on the expiry cycle.** `wdog_act`=0 in the same cycle as the stage-2 expiry tick: the block goes to IDLE.
- **Window check timing.** The check uses the registered cnt of the cycle in which the reload is sampled.
- **Output pulse widths.**
  - `wdog_win_err`: exactly 1 cycle.
  - `wdog_rst_req` and `wdog_irq`: levels, following state.
- **Reset mid-operation.** Asserting `sys_rst` in any state forces reset values immediately, with no clock required.

## Test plan
- **Basic two-stage expiry.**
  - Setup: `WDOG_CNT`=8, `PRE_DIV`=1, load=5; `wdog_act`=1 at cycle 0.
  - Required: cycle 1 cnt=5 in RUN; cycle 6 cnt=0; cycle 7 `wdog_irq`=1, cnt=5; cycle 13 `wdog_rst_req`=1, state=3.
- **Periodic feed.**
  - Setup: load=5; feed every 4 cycles.
  - Required: cnt never below 2, `wdog_irq` stays 0; a feed in IRQ returns to RUN with `wdog_irq`=0 next cycle.
- **Prescaler.**
  - Setup: `PRE_DIV`=4, load=2.
  - Required: each cnt value holds for 4 cycles; IRQ is entered 12 cycles after entering RUN.
- **Window mode.**
  - Setup: load=10, `wdog_win_val`=3, `wdog_win_en`=1.
  - Feed at cnt=7: `wdog_win_err` pulses 1 cycle, EXPIRED next cycle.
  - Feed at cnt=3 (fresh run): legal reload to 10.
- **Simultaneous events.**
  - Reload coinciding with the cnt=0 tick: reload to load value, no IRQ.
  - `wdog_act`=0 coinciding with the stage-2 tick: IDLE, `wdog_rst_req`=0.
- **Reset mid-operation.**
  - Assert `sys_rst` asynchronously in IRQ and in EXPIRED.
  - Required: all outputs return to reset values before the next `fclk` edge; re-activation afterwards works normally.

Source files
------------

// File: rtl/wdog_win_timer.sv
// Two-stage windowed watchdog: the first timeout raises an interrupt, the second
// requests a system reset. A prescaler sets the count rate, and an optional window rejects early feeds.
module wdog_win_timer #(
    parameter int WDOG_CNT = 16,
    parameter int PRE_DIV  = 1
) (
    input  logic                fclk,
    input  logic                sys_rst,
    input  logic                wdog_act,
    input  logic                wdog_reload,
    input  logic [WDOG_CNT-1:0] wdog_load_val,
    input  logic                wdog_win_en,
    input  logic [WDOG_CNT-1:0] wdog_win_val,
    output logic [WDOG_CNT-1:0] wdog_timer_cnt,
    output logic [1:0]          wdog_state,
    output logic                wdog_irq,
    output logic                wdog_rst_req,
    output logic                wdog_win_err
);
    localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        IRQ     = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t              state_q;
    logic [WDOG_CNT-1:0] cnt_q;
    logic [PRE_W-1:0]    pre_q;
    logic                irq_q;
    logic                rst_req_q;
    logic                win_err_q;
    logic                tick;
    logic                win_bad;

    assign tick    = (pre_q == PRE_LAST);
    // The window check uses the registered count of the cycle in which the feed is sampled.
    assign win_bad = wdog_win_en && (cnt_q > wdog_win_val);

    always_ff @(posedge fclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            irq_q     <= 1'b0;
            rst_req_q <= 1'b0;
            win_err_q <= 1'b0;
        end else begin
            win_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pre_q <= '0;
                    if (wdog_act) begin
                        cnt_q   <= wdog_load_val;
                        state_q <= RUN;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                RUN, IRQ: begin
                    if (!wdog_act) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        pre_q   <= '0;
                        irq_q   <= 1'b0;
                    end else if (wdog_reload) begin
                        pre_q <= '0;
                        irq_q <= 1'b0;
                        if (win_bad) begin
                            state_q   <= EXPIRED;
                            cnt_q     <= '0;
                            rst_req_q <= 1'b1;
                            win_err_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            cnt_q   <= wdog_load_val;
                        end
                    end else if (tick) begin
                        pre_q <= '0;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (state_q == RUN) begin
                            state_q <= IRQ;
                            cnt_q   <= wdog_load_val;
                            irq_q   <= 1'b1;
                        end else begin
                            state_q   <= EXPIRED;
                            cnt_q     <= '0;
                            irq_q     <= 1'b0;
                            rst_req_q <= 1'b1;
                        end
                    end else begin
                        pre_q <= pre_q + PRE_W'(1);
                    end
                end
                default: begin
                    // Terminal until sys_rst.
                    cnt_q     <= '0;
                    pre_q     <= '0;
                    irq_q     <= 1'b0;
                    rst_req_q <= 1'b1;
                end
            endcase
        end
    end

    assign wdog_timer_cnt = cnt_q;
    assign wdog_state     = state_q;
    assign wdog_irq       = irq_q;
    assign wdog_rst_req   = rst_req_q;
    assign wdog_win_err   = win_err_q;
endmodule

// File: tb/tb_wdog_win_timer.sv
// Directed bench for wdog_win_timer: one DUT with PRE_DIV=1 and one with PRE_DIV=4, both fed the same stimulus.
module tb_wdog_win_timer;
    logic       fclk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       act = 1'b0, reload = 1'b0, win_en = 1'b0;
    logic [7:0] load_val = 8'd0, win_val = 8'd0;
    logic [7:0] cnt1, cnt4;
    logic [1:0] st1, st4;
    logic       irq1, rr1, we1, irq4, rr4, we4;
    int         checks = 0;
    int         errors = 0;

    always #5 fclk = ~fclk;

    wdog_win_timer #(.WDOG_CNT(8), .PRE_DIV(1)) dut1 (
        .fclk(fclk), .sys_rst(sys_rst), .wdog_act(act), .wdog_reload(reload),
        .wdog_load_val(load_val), .wdog_win_en(win_en), .wdog_win_val(win_val),
        .wdog_timer_cnt(cnt1), .wdog_state(st1), .wdog_irq(irq1),
        .wdog_rst_req(rr1), .wdog_win_err(we1));

    wdog_win_timer #(.WDOG_CNT(8), .PRE_DIV(4)) dut4 (
        .fclk(fclk), .sys_rst(sys_rst), .wdog_act(act), .wdog_reload(reload),
        .wdog_load_val(load_val), .wdog_win_en(win_en), .wdog_win_val(win_val),
        .wdog_timer_cnt(cnt4), .wdog_state(st4), .wdog_irq(irq4),
        .wdog_rst_req(rr4), .wdog_win_err(we4));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic do_reset();
        act = 1'b0; reload = 1'b0; win_en = 1'b0; win_val = 8'd0;
        sys_rst = 1'b1;
        #3;
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        #2;
        checks++;
        if ({cnt1, st1, irq1, rr1, we1} !== 13'd0) begin
            errors++; $display("FAIL reset_dut1: got %0h expected 0", {cnt1, st1, irq1, rr1, we1});
        end
        checks++;
        if ({cnt4, st4, irq4, rr4, we4} !== 13'd0) begin
            errors++; $display("FAIL reset_dut4: got %0h expected 0", {cnt4, st4, irq4, rr4, we4});
        end
        sys_rst = 1'b0;
        step(3);
        checks++;
        if (st1 !== 2'd0 || cnt1 !== 8'd0) begin
            errors++; $display("FAIL idle_hold: got st=%0d cnt=%0d expected st=0 cnt=0", st1, cnt1);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load_val = 8'd5; act = 1'b1;
        step(1);
        checks++;
        if (cnt1 !== 8'd5 || st1 !== 2'd1) begin
            errors++; $display("FAIL basic_c1: got cnt=%0d st=%0d expected cnt=5 st=1", cnt1, st1);
        end
        step(5);
        checks++;
        if (cnt1 !== 8'd0 || irq1 !== 1'b0) begin
            errors++; $display("FAIL basic_c6: got cnt=%0d irq=%0d expected cnt=0 irq=0", cnt1, irq1);
        end
        step(1);
        checks++;
        if (irq1 !== 1'b1 || cnt1 !== 8'd5 || st1 !== 2'd2) begin
            errors++; $display("FAIL basic_c7: got irq=%0d cnt=%0d st=%0d expected 1 5 2", irq1, cnt1, st1);
        end
        step(5);
        checks++;
        if (rr1 !== 1'b0 || st1 !== 2'd2) begin
            errors++; $display("FAIL basic_c12: got rr=%0d st=%0d expected 0 2", rr1, st1);
        end
        step(1);
        checks++;
        if (rr1 !== 1'b1 || st1 !== 2'd3 || irq1 !== 1'b0 || cnt1 !== 8'd0) begin
            errors++; $display("FAIL basic_c13: got rr=%0d st=%0d irq=%0d cnt=%0d expected 1 3 0 0", rr1, st1, irq1, cnt1);
        end
        act = 1'b0; reload = 1'b1;
        step(2);
        reload = 1'b0;
        checks++;
        if (rr1 !== 1'b1 || st1 !== 2'd3) begin
            errors++; $display("FAIL expired_sticky: got rr=%0d st=%0d expected 1 3", rr1, st1);
        end
    endtask

    task automatic test_feed();
        do_reset();
        load_val = 8'd5; act = 1'b1;
        step(1);
        for (int i = 0; i < 20; i++) begin
            reload = (i % 4 == 3);
            step(1);
            checks++;
            if (cnt1 < 8'd2 || irq1 !== 1'b0) begin
                errors++; $display("FAIL feed_i%0d: got cnt=%0d irq=%0d expected cnt>=2 irq=0", i, cnt1, irq1);
            end
        end
        reload = 1'b0;
        step(6);
        checks++;
        if (st1 !== 2'd2 || irq1 !== 1'b1) begin
            errors++; $display("FAIL feed_to_irq: got st=%0d irq=%0d expected 2 1", st1, irq1);
        end
        reload = 1'b1;
        step(1);
        reload = 1'b0;
        checks++;
        if (st1 !== 2'd1 || irq1 !== 1'b0 || cnt1 !== 8'd5) begin
            errors++; $display("FAIL feed_in_irq: got st=%0d irq=%0d cnt=%0d expected 1 0 5", st1, irq1, cnt1);
        end
    endtask

    task automatic test_prescaler();
        do_reset();
        load_val = 8'd2; act = 1'b1;
        step(1);
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (cnt4 !== 8'(2 - (k - 1) / 4) || st4 !== 2'd1) begin
                errors++; $display("FAIL pre_c%0d: got cnt=%0d st=%0d expected cnt=%0d st=1", k, cnt4, st4, 2 - (k - 1) / 4);
            end
            step(1);
        end
        checks++;
        if (st4 !== 2'd2 || cnt4 !== 8'd2 || irq4 !== 1'b1) begin
            errors++; $display("FAIL pre_irq: got st=%0d cnt=%0d irq=%0d expected 2 2 1", st4, cnt4, irq4);
        end
    endtask

    task automatic test_window();
        do_reset();
        load_val = 8'd10; win_val = 8'd3; win_en = 1'b1; act = 1'b1;
        step(4);
        checks++;
        if (cnt1 !== 8'd7) begin
            errors++; $display("FAIL win_pre: got cnt=%0d expected 7", cnt1);
        end
        reload = 1'b1;
        step(1);
        reload = 1'b0;
        checks++;
        if (we1 !== 1'b1 || st1 !== 2'd3 || cnt1 !== 8'd0 || rr1 !== 1'b1) begin
            errors++; $display("FAIL win_err: got we=%0d st=%0d cnt=%0d rr=%0d expected 1 3 0 1", we1, st1, cnt1, rr1);
        end
        step(1);
        checks++;
        if (we1 !== 1'b0 || st1 !== 2'd3) begin
            errors++; $display("FAIL win_pulse: got we=%0d st=%0d expected 0 3", we1, st1);
        end
        do_reset();
        win_val = 8'd3; win_en = 1'b1; act = 1'b1;
        step(8);
        checks++;
        if (cnt1 !== 8'd3) begin
            errors++; $display("FAIL win_open_pre: got cnt=%0d expected 3", cnt1);
        end
        reload = 1'b1;
        step(1);
        reload = 1'b0;
        checks++;
        if (cnt1 !== 8'd10 || st1 !== 2'd1 || we1 !== 1'b0) begin
            errors++; $display("FAIL win_legal: got cnt=%0d st=%0d we=%0d expected 10 1 0", cnt1, st1, we1);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        load_val = 8'd5; act = 1'b1;
        step(6);
        reload = 1'b1;
        step(1);
        reload = 1'b0;
        checks++;
        if (st1 !== 2'd1 || cnt1 !== 8'd5 || irq1 !== 1'b0) begin
            errors++; $display("FAIL feed_on_tick: got st=%0d cnt=%0d irq=%0d expected 1 5 0", st1, cnt1, irq1);
        end
        step(11);
        checks++;
        if (st1 !== 2'd2 || cnt1 !== 8'd0) begin
            errors++; $display("FAIL pre_stage2: got st=%0d cnt=%0d expected 2 0", st1, cnt1);
        end
        act = 1'b0;
        step(1);
        checks++;
        if (st1 !== 2'd0 || rr1 !== 1'b0 || irq1 !== 1'b0) begin
            errors++; $display("FAIL disable_on_expiry: got st=%0d rr=%0d irq=%0d expected 0 0 0", st1, rr1, irq1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_val = 8'd5; act = 1'b1;
        step(7);
        checks++;
        if (st1 !== 2'd2 || irq1 !== 1'b1) begin
            errors++; $display("FAIL ar_irq_setup: got st=%0d irq=%0d expected 2 1", st1, irq1);
        end
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({cnt1, st1, irq1, rr1, we1} !== 13'd0) begin
            errors++; $display("FAIL ar_in_irq: got %0h expected 0", {cnt1, st1, irq1, rr1, we1});
        end
        sys_rst = 1'b0;
        step(1);
        checks++;
        if (st1 !== 2'd1 || cnt1 !== 8'd5) begin
            errors++; $display("FAIL ar_reactivate: got st=%0d cnt=%0d expected 1 5", st1, cnt1);
        end
        step(12);
        checks++;
        if (st1 !== 2'd3 || rr1 !== 1'b1) begin
            errors++; $display("FAIL ar_exp_setup: got st=%0d rr=%0d expected 3 1", st1, rr1);
        end
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({cnt1, st1, irq1, rr1, we1} !== 13'd0) begin
            errors++; $display("FAIL ar_in_expired: got %0h expected 0", {cnt1, st1, irq1, rr1, we1});
        end
        act = 1'b0;
        sys_rst = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_feed();
        test_prescaler();
        test_window();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
